// File: rtl/spi_slave.sv
// spi_slave: SPI frame deserialiser / read-data serialiser for the RAM command port
// SCK is clk; SS_n and MOSI are sampled on posedge clk.
// Ports:
//   clk, rst        system/SPI clock, synchronous active-high reset
//   SS_n, MOSI      slave select (active-low) and serial data in, MSB first
//   MISO            registered serial data out
//   rx_data         assembled ADDR_SIZE+2 bit frame, [ADDR_SIZE+1:ADDR_SIZE] is the opcode
//   rx_valid        one-cycle strobe, rx_data valid
//   tx_data         read byte from the RAM
//   tx_valid        tx_data valid (level, may stay high)
// Optional macro SPI_SLAVE_TX_TIMEOUT_EN adds parameter TX_TIMEOUT: if tx_valid is not
// seen within TX_TIMEOUT wait cycles, eight zero bits are sent and rd_flag clears.
module spi_slave #(
   parameter int ADDR_SIZE = 8
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
   , parameter int TX_TIMEOUT = 16
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [ADDR_SIZE+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [ADDR_SIZE-1:0] tx_data,
   input  logic                 tx_valid
);
   localparam int CW = $clog2(ADDR_SIZE + 2);
   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
   // Sub-phase shared by the three data states; WRITE/READ_ADD go straight PH_RX -> PH_DONE.
   typedef enum logic [1:0] {PH_RX, PH_WAIT, PH_SHIFT, PH_DONE} phase_t;
   state_t               state;
   phase_t               phase;
   logic [CW-1:0]        cnt;
   logic [ADDR_SIZE:0]   rx_sh;
   logic [ADDR_SIZE-1:0] tx_sh;
   logic                 rd_flag;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
   localparam int TW = $clog2(TX_TIMEOUT + 1);
   logic [TW-1:0]        tcnt;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         phase    <= PH_RX;
         cnt      <= '0;
         rx_sh    <= '0;
         tx_sh    <= '0;
         rd_flag  <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         MISO     <= 1'b0;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
         tcnt     <= '0;
`endif
      end else begin
         rx_valid <= 1'b0;
         MISO     <= 1'b0;
         if (state != IDLE && SS_n) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (!SS_n) state <= CHK_CMD;
               CHK_CMD: begin
                  rx_sh <= {{ADDR_SIZE{1'b0}}, MOSI};
                  cnt   <= '0;
                  phase <= PH_RX;
                  state <= !MOSI ? WRITE : (rd_flag ? READ_DATA : READ_ADD);
               end
               default: begin
                  case (phase)
                     PH_RX: begin
                        rx_sh <= {rx_sh[ADDR_SIZE-1:0], MOSI};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(ADDR_SIZE)) begin
                           rx_data  <= {rx_sh, MOSI};
                           rx_valid <= 1'b1;
                           cnt      <= '0;
                           phase    <= (state == READ_DATA) ? PH_WAIT : PH_DONE;
                           if (state == READ_ADD) rd_flag <= 1'b1;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
                           tcnt     <= '0;
`endif
                        end
                     end
                     PH_WAIT: begin
                        if (tx_valid) begin
                           tx_sh <= tx_data;
                           phase <= PH_SHIFT;
                        end
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
                        else if (tcnt == TW'(TX_TIMEOUT - 1)) begin
                           tx_sh <= '0;
                           phase <= PH_SHIFT;
                        end else begin
                           tcnt <= tcnt + 1'b1;
                        end
`endif
                     end
                     PH_SHIFT: begin
                        MISO  <= tx_sh[ADDR_SIZE-1];
                        tx_sh <= tx_sh << 1;
                        cnt   <= cnt + 1'b1;
                        // rd_flag clears with the last bit so an SS_n rise right after
                        // a complete serialisation still counts as completed.
                        if (cnt == CW'(ADDR_SIZE - 1)) begin
                           rd_flag <= 1'b0;
                           phase   <= PH_DONE;
                        end
                     end
                     default: ;
                  endcase
               end
            endcase
         end
      end
   end
endmodule
